// File: rtl/longest_run_pkg.sv
// Shared types and helpers for the longest-run detector: FSM states, match-value
// constants and a clipping adder that also reports whether it clipped.
package longest_run_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam bit MATCH_ONES  = 1'b1;
  localparam bit MATCH_ZEROS = 1'b0;

  typedef struct packed {
    logic        clip;
    logic [31:0] val;
  } sat_t;

  function automatic sat_t sat_add(input logic [31:0] a, input logic [31:0] b,
                                   input logic [31:0] lim);
    logic [32:0] sum;
    sat_t        r;
    sum    = {1'b0, a} + {1'b0, b};
    r.clip = (sum > {1'b0, lim});
    r.val  = r.clip ? lim : sum[31:0];
    return r;
  endfunction

endpackage

// File: rtl/longest_run_detector_if.sv
// Beat input stream and single-result output stream of the longest-run detector.
// The detector is the slave; the bit-stream source / statistics sink is the master.
interface longest_run_detector_if #(
  parameter int DIN_W = 3,
  parameter int LEN_W = 8,
  parameter int POS_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [DIN_W-1:0] din;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [LEN_W-1:0] length;
  logic [POS_W-1:0] run_start;
  logic             saturated;

  modport master (
    output in_valid, din, in_last, out_ready,
    input  in_ready, out_valid, length, run_start, saturated
  );

  modport slave (
    input  in_valid, din, in_last, out_ready,
    output in_ready, out_valid, length, run_start, saturated
  );
endinterface

// File: rtl/run_scan.sv
// Combinational per-beat scan: leading/trailing match counts, longest run in the beat
// and its offset (0 = earliest bit, i.e. din MSB). Zero latency, no handshake.
module run_scan
  import longest_run_pkg::*;
#(
  parameter int  DIN_W     = 3,
  parameter bit  MATCH_BIT = MATCH_ONES,
  localparam int CW        = $clog2(DIN_W + 1),
  localparam int OW        = (DIN_W > 1) ? $clog2(DIN_W) : 1
) (
  input  logic [DIN_W-1:0] din,
  output logic [CW-1:0]    lead,
  output logic [CW-1:0]    trail,
  output logic [CW-1:0]    inner,
  output logic [OW-1:0]    inner_off,
  output logic             all_match
);

  logic [CW-1:0] run;
  logic [OW-1:0] run_off;
  logic          in_lead;

  // Walk bits in arrival order; strict > keeps the earliest of equal-length runs.
  always_comb begin
    lead      = '0;
    inner     = '0;
    inner_off = '0;
    run       = '0;
    run_off   = '0;
    in_lead   = 1'b1;
    for (int t = 0; t < DIN_W; t++) begin
      if (din[DIN_W-1-t] == MATCH_BIT) begin
        if (run == '0) run_off = OW'(t);
        run = run + CW'(1);
        if (in_lead) lead = lead + CW'(1);
        if (run > inner) begin
          inner     = run;
          inner_off = run_off;
        end
      end else begin
        run     = '0;
        in_lead = 1'b0;
      end
    end
    trail     = run;
    all_match = (lead == CW'(DIN_W));
  end

endmodule

// File: rtl/longest_run_detector.sv
// Longest run of MATCH_BIT per frame with its start offset; result registered one cycle after the
// in_last beat, single-buffered, and in_ready drops while a result waits for out_ready or clear is high.
module longest_run_detector
  import longest_run_pkg::*;
#(
  parameter int DIN_W     = 3,
  parameter int LEN_W     = 8,
  parameter int POS_W     = 8,
  parameter bit MATCH_BIT = MATCH_ONES
) (
  input logic clk,
  input logic rst_n,
  input logic clear,
  longest_run_detector_if.slave bus
);

  localparam int          CW      = $clog2(DIN_W + 1);
  localparam int          OW      = (DIN_W > 1) ? $clog2(DIN_W) : 1;
  localparam logic [31:0] LEN_MAX = 32'((64'd1 << LEN_W) - 64'd1);
  localparam logic [31:0] POS_MAX = 32'((64'd1 << POS_W) - 64'd1);

  state_t           state;
  logic [LEN_W-1:0] cur, best, len_q;
  logic [POS_W-1:0] cur_start, best_start, pos, start_q;
  logic             sat, sat_q, out_valid_q;

  logic [CW-1:0]    lead, trail, inner;
  logic [OW-1:0]    inner_off;
  logic             all_match, accept;

  sat_t             ext, inner_sat, tr, in_abs, tail_start, pos_adv;
  logic [POS_W-1:0] ext_start, cand_start, best_start_next, cur_start_next;
  logic [LEN_W-1:0] cand_len, best_next, cur_next;
  logic             sat_next;

  run_scan #(.DIN_W(DIN_W), .MATCH_BIT(MATCH_BIT)) u_scan (
    .din       (bus.din),
    .lead      (lead),
    .trail     (trail),
    .inner     (inner),
    .inner_off (inner_off),
    .all_match (all_match)
  );

  assign bus.in_ready  = !clear && !(out_valid_q && !bus.out_ready);
  assign accept        = bus.in_valid && bus.in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.length    = len_q;
  assign bus.run_start = start_q;
  assign bus.saturated = sat_q;

  always_comb begin
    ext        = sat_add(32'(cur), 32'(lead), LEN_MAX);
    inner_sat  = sat_add(32'(inner), 32'd0, LEN_MAX);
    tr         = sat_add(32'(trail), 32'd0, LEN_MAX);
    in_abs     = sat_add(32'(pos), 32'(inner_off), POS_MAX);
    tail_start = sat_add(32'(pos), 32'(DIN_W) - 32'(trail), POS_MAX);
    pos_adv    = sat_add(32'(pos), 32'(DIN_W), POS_MAX);
    ext_start  = (cur == '0) ? pos : cur_start;

    // A run continuing from earlier beats starts no later than any in-beat run, so it wins ties.
    if (ext.val >= inner_sat.val) begin
      cand_len   = LEN_W'(ext.val);
      cand_start = ext_start;
    end else begin
      cand_len   = LEN_W'(inner_sat.val);
      cand_start = POS_W'(in_abs.val);
    end

    best_next       = best;
    best_start_next = best_start;
    if (cand_len > best) begin
      best_next       = cand_len;
      best_start_next = cand_start;
    end

    cur_next       = all_match ? LEN_W'(ext.val) : LEN_W'(tr.val);
    cur_start_next = all_match ? ext_start : POS_W'(tail_start.val);
    sat_next       = sat | ext.clip | inner_sat.clip | tr.clip | pos_adv.clip;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cur         <= '0;
      cur_start   <= '0;
      best        <= '0;
      best_start  <= '0;
      pos         <= '0;
      sat         <= 1'b0;
      out_valid_q <= 1'b0;
      len_q       <= '0;
      start_q     <= '0;
      sat_q       <= 1'b0;
    end else begin
      if (out_valid_q && bus.out_ready) begin
        out_valid_q <= 1'b0;
        state       <= IDLE;
      end
      if (clear) begin
        cur        <= '0;
        cur_start  <= '0;
        best       <= '0;
        best_start <= '0;
        pos        <= '0;
        sat        <= 1'b0;
        if (state == RUN) state <= IDLE;
      end else if (accept) begin
        if (bus.in_last) begin
          len_q       <= best_next;
          start_q     <= best_start_next;
          sat_q       <= sat_next;
          out_valid_q <= 1'b1;
          state       <= DONE;
          cur         <= '0;
          cur_start   <= '0;
          best        <= '0;
          best_start  <= '0;
          pos         <= '0;
          sat         <= 1'b0;
        end else begin
          cur        <= cur_next;
          cur_start  <= cur_start_next;
          best       <= best_next;
          best_start <= best_start_next;
          pos        <= POS_W'(pos_adv.val);
          sat        <= sat_next;
          state      <= RUN;
        end
      end
    end
  end

endmodule

// File: tb/tb_longest_run_detector.sv
// Bench: three detector instances (ones, zeros, 4-bit length) on shared stimulus, expected
// results queued per instance and popped by per-instance monitors at result handshakes.
module tb_longest_run_detector;
  import longest_run_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clear = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_last = 1'b0;
  logic       out_ready = 1'b1;
  logic [2:0] din = '0;
  int         sel = 0;
  logic       rdy_sel;

  always #5 clk = ~clk;

  longest_run_detector_if #(.DIN_W(3), .LEN_W(8), .POS_W(8)) ifa ();
  longest_run_detector_if #(.DIN_W(3), .LEN_W(8), .POS_W(8)) ifz ();
  longest_run_detector_if #(.DIN_W(3), .LEN_W(4), .POS_W(8)) ifs ();

  assign ifa.in_valid  = in_valid && (sel == 0);
  assign ifz.in_valid  = in_valid && (sel == 1);
  assign ifs.in_valid  = in_valid && (sel == 2);
  assign ifa.din       = din;
  assign ifz.din       = din;
  assign ifs.din       = din;
  assign ifa.in_last   = in_last;
  assign ifz.in_last   = in_last;
  assign ifs.in_last   = in_last;
  assign ifa.out_ready = out_ready;
  assign ifz.out_ready = out_ready;
  assign ifs.out_ready = out_ready;

  longest_run_detector #(.DIN_W(3), .LEN_W(8), .POS_W(8), .MATCH_BIT(MATCH_ONES)) dut_a (
    .clk(clk), .rst_n(rst_n), .clear(clear), .bus(ifa));
  longest_run_detector #(.DIN_W(3), .LEN_W(8), .POS_W(8), .MATCH_BIT(MATCH_ZEROS)) dut_z (
    .clk(clk), .rst_n(rst_n), .clear(clear), .bus(ifz));
  longest_run_detector #(.DIN_W(3), .LEN_W(4), .POS_W(8), .MATCH_BIT(MATCH_ONES)) dut_s (
    .clk(clk), .rst_n(rst_n), .clear(clear), .bus(ifs));

  always_comb begin
    rdy_sel = ifa.in_ready;
    if (sel == 1)      rdy_sel = ifz.in_ready;
    else if (sel == 2) rdy_sel = ifs.in_ready;
  end

  typedef struct {
    int len;
    int st;
    int sat;
  } exp_t;

  exp_t qa[$];
  exp_t qz[$];
  exp_t qs[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic cmp_res(input string tag, input exp_t e, input int len, input int st, input int sat);
    check({tag, "_length"}, len, e.len);
    check({tag, "_run_start"}, st, e.st);
    check({tag, "_saturated"}, sat, e.sat);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && ifa.out_valid && ifa.out_ready) begin
      if (qa.size() == 0) check("a_unexpected_result", qa.size(), 1);
      else begin
        e = qa.pop_front();
        cmp_res("a", e, int'(ifa.length), int'(ifa.run_start), int'(ifa.saturated));
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && ifz.out_valid && ifz.out_ready) begin
      if (qz.size() == 0) check("z_unexpected_result", qz.size(), 1);
      else begin
        e = qz.pop_front();
        cmp_res("z", e, int'(ifz.length), int'(ifz.run_start), int'(ifz.saturated));
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && ifs.out_valid && ifs.out_ready) begin
      if (qs.size() == 0) check("s_unexpected_result", qs.size(), 1);
      else begin
        e = qs.pop_front();
        cmp_res("s", e, int'(ifs.length), int'(ifs.run_start), int'(ifs.saturated));
      end
    end
  end

  task automatic push(input int which, input int len, input int st, input int sat);
    exp_t e;
    e.len = len;
    e.st  = st;
    e.sat = sat;
    if (which == 0)      qa.push_back(e);
    else if (which == 1) qz.push_back(e);
    else                 qs.push_back(e);
  endtask

  // Inputs change 1 time unit after posedge; acceptance is judged at the preceding negedge.
  task automatic beat(input logic [2:0] d, input logic last);
    bit got;
    got      = 1'b0;
    in_valid = 1'b1;
    din      = d;
    in_last  = last;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (rdy_sel) begin
        @(posedge clk);
        #1;
        got = 1'b1;
      end
    end
    if (!got) check("beat_accept_timeout", got, 1);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 200; i++) begin
      if (qa.size() + qz.size() + qs.size() == 0) break;
      @(posedge clk);
    end
    #1;
    check("drain_pending", qa.size() + qz.size() + qs.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    #1;
    check("rst_out_valid", ifa.out_valid, 0);
    check("rst_length", ifa.length, 0);
    check("rst_run_start", ifa.run_start, 0);
    check("rst_saturated", ifa.saturated, 0);
    check("rst_z_out_valid", ifz.out_valid, 0);
    check("rst_s_out_valid", ifs.out_valid, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    check("rst_in_ready", ifa.in_ready, 1);

    sel = 0;
    push(0, 6, 0, 0);
    beat(3'b111, 0); beat(3'b111, 0); beat(3'b001, 1);
    push(0, 4, 1, 0);
    beat(3'b011, 0); beat(3'b110, 0); beat(3'b000, 1);
    push(0, 2, 0, 0);
    beat(3'b110, 0); beat(3'b011, 1);
    push(0, 0, 0, 0);
    beat(3'b000, 0); beat(3'b000, 1);

    sel = 1;
    push(1, 3, 1, 0);
    beat(3'b100, 0); beat(3'b010, 1);
    push(1, 0, 0, 0);
    beat(3'b111, 1);

    sel = 2;
    push(2, 15, 0, 1);
    for (int i = 0; i < 5; i++) beat(3'b111, 0);
    beat(3'b111, 1);
    push(2, 1, 0, 0);
    beat(3'b101, 1);
    drain();

    // Stalled result: held output, no beat taken, ready returns with out_ready.
    sel = 0;
    out_ready = 1'b0;
    push(0, 6, 0, 0);
    beat(3'b111, 0); beat(3'b111, 0); beat(3'b001, 1);
    push(0, 3, 0, 0);
    in_valid = 1'b1; din = 3'b111; in_last = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("stall_out_valid", ifa.out_valid, 1);
      check("stall_in_ready", ifa.in_ready, 0);
      check("stall_length", ifa.length, 6);
      check("stall_run_start", ifa.run_start, 0);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    #1 check("stall_ready_same_cycle", ifa.in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0; in_last = 1'b0;
    drain();

    // clear mid-frame
    beat(3'b111, 0); beat(3'b111, 0);
    clear = 1'b1;
    @(negedge clk);
    check("clear_in_ready", ifa.in_ready, 0);
    @(posedge clk);
    #1 clear = 1'b0;
    push(0, 4, 1, 0);
    beat(3'b011, 0); beat(3'b110, 0); beat(3'b000, 1);
    drain();

    // reset while a result is pending, then mid-frame
    out_ready = 1'b0;
    beat(3'b111, 1);
    @(negedge clk);
    check("pend_out_valid", ifa.out_valid, 1);
    check("pend_length", ifa.length, 3);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_out_valid", ifa.out_valid, 0);
    check("async_rst_length", ifa.length, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    beat(3'b111, 0);
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    push(0, 2, 0, 0);
    beat(3'b110, 0); beat(3'b011, 1);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
